// File: rtl/difftest_store_seq_pkg.sv
// Shared types for the difftest store sequencer.
// Holds the drain FSM encoding and the queued store-entry record.
package difftest_store_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int ENTRY_W = 8 + 64 + 64 + 64;

  typedef struct packed {
    logic [7:0]  typ;
    logic [63:0] paddr;
    logic [63:0] vaddr;
    logic [63:0] data;
  } store_t;

  function automatic logic lane_live(
    input logic       v,
    input logic [7:0] t
  );
    return v && (t != 8'd0);
  endfunction

endpackage

// File: rtl/difftest_store_fifo.sv
// Dual-push, single-pop store queue of DEPTH entries.
// Ports: i_push_a/i_data_a first slot, i_push_b/i_data_b second
// slot (only with a), i_pop, o_head (oldest), o_count (entries).
module difftest_store_fifo
  import difftest_store_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push_a,
  input  store_t                   i_data_a,
  input  logic                     i_push_b,
  input  store_t                   i_data_b,
  input  logic                     i_pop,
  output store_t                   o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  store_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic [AW-1:0]   w_wptr_b;
  logic [1:0]      w_npush;
  logic            w_pop;

  assign w_wptr_b = r_wptr + 1'b1;
  assign w_npush  = {1'b0, i_push_a} + {1'b0, i_push_b};
  assign w_pop    = i_pop && (r_count != '0);
  assign o_head   = r_mem[r_rptr];
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (i_push_a) r_mem[r_wptr]   <= i_data_a;
    if (i_push_b) r_mem[w_wptr_b] <= i_data_b;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_npush);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_npush)
                         - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/difftest_store_seq.sv
// Collects two commit-lane stores into a queue and replays them
// one per cycle on a registered difftest store-event port.
// Ports: lane strobes/type/addr/data in, in_ready, drain_req/done,
// store* event outputs, occupancy, sticky overflow_err.
module difftest_store_seq
  import difftest_store_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid_0,
  input  logic                   in_valid_1,
  input  logic [7:0]             in_type_0,
  input  logic [7:0]             in_type_1,
  input  logic [63:0]            in_paddr_0,
  input  logic [63:0]            in_paddr_1,
  input  logic [63:0]            in_vaddr_0,
  input  logic [63:0]            in_vaddr_1,
  input  logic [63:0]            in_data_0,
  input  logic [63:0]            in_data_1,
  output logic                   in_ready,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic [7:0]             storeIndex,
  output logic [7:0]             storeValid,
  output logic [63:0]            storePaddr,
  output logic [63:0]            storeVaddr,
  output logic [63:0]            storeData,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH - 2);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_idx;
  logic        r_ovf;

  logic        w_live0;
  logic        w_live1;
  logic        w_ready;
  logic        w_acc0;
  logic        w_acc1;
  logic        w_pop;
  store_t      w_e0;
  store_t      w_e1;
  store_t      w_head;
  logic [AW:0] w_count;

  assign w_live0 = lane_live(in_valid_0, in_type_0);
  assign w_live1 = lane_live(in_valid_1, in_type_1);
  assign w_ready = (r_state == ST_RUN) && (w_count <= LIM);
  assign w_acc0  = w_live0 && w_ready;
  assign w_acc1  = w_live1 && w_ready;
  assign w_pop   = (w_count != '0);

  assign w_e0 = '{in_type_0, in_paddr_0, in_vaddr_0, in_data_0};
  assign w_e1 = '{in_type_1, in_paddr_1, in_vaddr_1, in_data_1};

  // Lane 1 takes the first slot when lane 0 is idle.
  difftest_store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_push_a (w_acc0 || w_acc1),
    .i_data_a (w_acc0 ? w_e0 : w_e1),
    .i_push_b (w_acc0 && w_acc1),
    .i_data_b (w_e1),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:   if (drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_count == '0) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      storeValid <= '0;
      storeIndex <= '0;
      storePaddr <= '0;
      storeVaddr <= '0;
      storeData  <= '0;
      r_idx      <= '0;
    end else if (w_pop) begin
      storeValid <= w_head.typ;
      storeIndex <= r_idx;
      storePaddr <= w_head.paddr;
      storeVaddr <= w_head.vaddr;
      storeData  <= w_head.data;
      r_idx      <= r_idx + 8'd1;
    end else begin
      storeValid <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_ovf <= 1'b0;
    else if ((w_live0 || w_live1) && !w_ready) r_ovf <= 1'b1;
  end

  assign in_ready     = w_ready;
  assign drain_done   = (r_state == ST_DONE);
  assign occupancy    = w_count;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_difftest_store_seq.sv
// Scoreboard bench for difftest_store_seq.
// Expected events queued at accept time, compared on emission.
module tb_difftest_store_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid_0, in_valid_1;
  logic [7:0]  in_type_0, in_type_1;
  logic [63:0] in_paddr_0, in_paddr_1;
  logic [63:0] in_vaddr_0, in_vaddr_1;
  logic [63:0] in_data_0, in_data_1;
  logic        in_ready;
  logic        drain_req;
  logic        drain_done;
  logic [7:0]  storeIndex, storeValid;
  logic [63:0] storePaddr, storeVaddr, storeData;
  logic [3:0]  occupancy;
  logic        overflow_err;

  always #5 clock = ~clock;

  difftest_store_seq #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_type_0(in_type_0), .in_type_1(in_type_1),
    .in_paddr_0(in_paddr_0), .in_paddr_1(in_paddr_1),
    .in_vaddr_0(in_vaddr_0), .in_vaddr_1(in_vaddr_1),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
    .in_ready(in_ready), .drain_req(drain_req),
    .drain_done(drain_done), .storeIndex(storeIndex),
    .storeValid(storeValid), .storePaddr(storePaddr),
    .storeVaddr(storeVaddr), .storeData(storeData),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  typedef struct {
    logic [7:0]  t;
    logic [63:0] pa;
    logic [7:0]  idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          m_occ;
  int          m_st;
  logic        m_ovf;
  logic [7:0]  m_idx;
  int          n_ev;
  logic [63:0] pbase;

  localparam logic [63:0] VX = 64'hFFFF_0000_0000_0000;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic m_ready();
    return (m_st == 0) && ((8 - m_occ) >= 2);
  endfunction

  task automatic model_clr();
    sb.delete();
    m_occ = 0;
    m_st  = 0;
    m_ovf = 1'b0;
    m_idx = 8'd0;
    n_ev  = 0;
  endtask

  task automatic idle_in();
    in_valid_0 = 0; in_valid_1 = 0;
    in_type_0  = 0; in_type_1  = 0;
    in_paddr_0 = 0; in_paddr_1 = 0;
    in_vaddr_0 = 0; in_vaddr_1 = 0;
    in_data_0  = 0; in_data_1  = 0;
    drain_req  = 0;
  endtask

  task automatic cyc(input logic v0, input logic [7:0] t0,
                     input logic [63:0] p0,
                     input logic v1, input logic [7:0] t1,
                     input logic [63:0] p1,
                     input logic dr);
    int   acc;
    logic rdy;
    logic pop;
    in_valid_0 = v0; in_type_0 = t0; in_paddr_0 = p0;
    in_vaddr_0 = p0 ^ VX; in_data_0 = ~p0;
    in_valid_1 = v1; in_type_1 = t1; in_paddr_1 = p1;
    in_vaddr_1 = p1 ^ VX; in_data_1 = ~p1;
    drain_req  = dr;
    #1;
    rdy = m_ready();
    chk("in_ready", in_ready, rdy);
    acc = 0;
    if (v0 && t0 != 0) begin
      if (rdy) begin
        sb.push_back('{t0, p0, m_idx});
        m_idx++; acc++;
      end else m_ovf = 1'b1;
    end
    if (v1 && t1 != 0) begin
      if (rdy) begin
        sb.push_back('{t1, p1, m_idx});
        m_idx++; acc++;
      end else m_ovf = 1'b1;
    end
    @(posedge clock); #1;
    pop = (m_occ != 0);
    if (m_st == 0 && dr) m_st = 1;
    else if (m_st == 1 && m_occ == 0) m_st = 2;
    m_occ = m_occ + acc - int'(pop);
    chk("occupancy", occupancy, m_occ);
    chk("overflow_err", overflow_err, m_ovf);
    chk("drain_done", drain_done, m_st == 2);
    idle_in();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    @(posedge clock); #1;
    model_clr();
    reset = 1'b0;
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset && storeValid != 8'd0) begin
      n_ev++;
      if (sb.size() == 0) begin
        chk("spurious_event", storeValid, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ev_type", storeValid, mon_e.t);
        chk("ev_paddr", storePaddr, mon_e.pa);
        chk("ev_vaddr", storeVaddr, mon_e.pa ^ VX);
        chk("ev_data", storeData, ~mon_e.pa);
        chk("ev_index", storeIndex, mon_e.idx);
      end
    end
  end

  initial begin
    idle_in();
    model_clr();
    do_reset();
    chk("rst_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", storeValid, 0);
    chk("rst_index", storeIndex, 0);
    chk("rst_paddr", storePaddr, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_ovf", overflow_err, 0);

    // single lane-0 store, two-edge latency
    cyc(1, 8'h04, 64'h1000, 0, 0, 0, 0);
    chk("lat_e0_valid", storeValid, 0);
    idle(1);
    chk("lat_e1_valid", storeValid, 8'h04);
    chk("lat_e1_paddr", storePaddr, 64'h1000);
    chk("lat_e1_index", storeIndex, 0);
    idle(1);
    chk("lat_e2_valid", storeValid, 0);
    chk("lat_e2_hold", storePaddr, 64'h1000);

    // both lanes, lane 0 first; type-0 lane ignored
    do_reset();
    cyc(1, 8'h01, 64'hA0, 1, 8'h02, 64'hB0, 0);
    idle(1);
    chk("dual_first_pa", storePaddr, 64'hA0);
    chk("dual_first_ix", storeIndex, 0);
    idle(1);
    chk("dual_second_pa", storePaddr, 64'hB0);
    chk("dual_second_ix", storeIndex, 1);
    cyc(1, 8'h00, 64'hC0, 0, 0, 0, 0);
    chk("type0_occ", occupancy, 0);
    idle(3);
    chk("dual_sb_empty", sb.size(), 0);

    // fill until in_ready drops, then overflow
    do_reset();
    pbase = 64'h5000;
    for (int i = 0; i < 20 && m_ready(); i++) begin
      cyc(1, 8'h08, pbase, 1, 8'h08, pbase + 8, 0);
      pbase += 16;
    end
    chk("full_occ", occupancy, 7);
    chk("full_ready", in_ready, 0);
    cyc(1, 8'h08, 64'h9999, 0, 0, 0, 0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_occ", occupancy, 6);
    idle(10);
    chk("ovf_sb_empty", sb.size(), 0);
    chk("ovf_sticky", overflow_err, 1);

    // 258 singles, index wraps 255 -> 0
    do_reset();
    for (int i = 0; i < 258; i++)
      cyc(1, 8'h10, 64'h2000 + 64'(i), 0, 0, 0, 0);
    idle(4);
    chk("wrap_events", n_ev, 258);
    chk("wrap_last_ix", storeIndex, 1);
    chk("wrap_sb_empty", sb.size(), 0);

    // drain with pushes in the request cycle
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1, 8'h20, 64'h7000 + 64'(2*i),
          1, 8'h20, 64'h7001 + 64'(2*i), 0);
    cyc(1, 8'h20, 64'h7100, 1, 8'h20, 64'h7101, 1);
    chk("drain_occ", occupancy, 5);
    chk("drain_ready", in_ready, 0);
    for (int i = 0; i < 20 && m_st != 2; i++) idle(1);
    chk("drain_done_end", drain_done, 1);
    chk("drain_events", n_ev, 8);
    chk("drain_sb_empty", sb.size(), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("done_sticky", drain_done, 1);

    // asynchronous reset with entries queued
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(1, 8'h40, 64'h8000 + 64'(2*i),
          1, 8'h40, 64'h8001 + 64'(2*i), 0);
    chk("pre_rst_occ", occupancy, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", storeValid, 0);
    chk("arst_paddr", storePaddr, 0);
    chk("arst_index", storeIndex, 0);
    chk("arst_occ", occupancy, 0);
    @(posedge clock); #1;
    model_clr();
    reset = 1'b0;
    #1;
    idle(8);
    chk("post_rst_events", n_ev, 0);
    chk("post_rst_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_store_seq.md
DIFFTEST_STORE_SEQ -- requirements
Module: difftest_store_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=4).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid_0 / in_valid_1  in  1 each  commit-lane store strobes; lane 0 is older.
REQ-005 SHALL have ports in_type_0 / in_type_1  in  8 each  store-type one-hot code, driven unchanged onto storeValid.
REQ-006 SHALL have ports in_paddr_0/1, in_vaddr_0/1, in_data_0/1  in  64 each  store physical address, virtual address, data.
REQ-007 SHALL have port in_ready  out  1  high when two pushes can be accepted this cycle.
REQ-008 SHALL have port drain_req  in  1  end-of-run request to stop intake and empty the queue.
REQ-009 SHALL have port drain_done  out  1  queue empty after drain; sticky until reset.
REQ-010 SHALL have ports storeIndex  out 8, storeValid  out 8, storePaddr / storeVaddr / storeData  out 64 each  registered store-event port feeding the difftest store event.
REQ-011 SHALL have port occupancy  out  log2(DEPTH)+1  current entry count.
REQ-012 SHALL have port overflow_err  out  1  sticky: a store was presented while in_ready was low.

Function
REQ-013 SHALL accept a lane only if in_valid_n=1, in_type_n!=0 and in_ready=1; lanes with type 0 are ignored.
REQ-014 SHALL enqueue lane 0 before lane 1 in the same cycle; lane 1 alone occupies one slot.
REQ-015 SHALL drive in_ready = (state==RUN) and (DEPTH-occupancy >= 2), registered-free: combinational from current state.
REQ-016 SHALL drop any valid store presented while in_ready=0 and set overflow_err the next cycle.
REQ-017 SHALL pop at most one entry per cycle whenever the queue is non-empty at the clock edge, loading it into the output registers.
REQ-018 SHALL drive storeValid=0 in any cycle following an edge with no pop; address/data/index outputs hold.
REQ-019 SHALL have latency 2 edges: store sampled at edge E0 appears on outputs after edge E1 when the queue was empty.
REQ-020 SHALL assign storeIndex from an 8-bit counter that increments per emitted event and wraps 255->0.
REQ-021 SHALL handle simultaneous push (1 or 2) and pop in one cycle: occupancy += pushes - pop.
REQ-022 SHALL use wrap-around read/write pointers of log2(DEPTH) bits; full when occupancy==DEPTH, empty when 0.
REQ-023 SHALL implement FSM RUN -> DRAIN on drain_req=1; DRAIN -> DONE when occupancy==0 and no pop pending; DONE is terminal until reset.
REQ-024 SHALL hold in_ready=0 in DRAIN and DONE; drain_done=1 only in DONE.
REQ-025 SHALL ignore drain_req in DRAIN/DONE; a drain_req in the same cycle as accepted pushes still enqueues those pushes.

Reset
REQ-026 SHALL on reset clear pointers, occupancy, index counter, overflow_err, drain_done and storeValid to 0, set state RUN, and zero storePaddr/storeVaddr/storeData/storeIndex.
REQ-027 SHALL discard queue contents on reset asserted mid-operation; no partial event is emitted after reset release.

Structure
REQ-028 SHALL place the FSM state encoding (RUN, DRAIN, DONE) and the store-entry record width (8+64+64+64) in the shared difftest package.
REQ-029 SHALL instantiate one sub-module, difftest_store_fifo: dual-push, single-pop FIFO of DEPTH entries.

Verification
REQ-030 SHALL cover: single lane-0 store paddr=0x1000, type=0x04 at E0 -> storeValid=0x04, storePaddr=0x1000, storeIndex=0 after E1, storeValid=0 after E2.
REQ-031 SHALL cover: both lanes valid (paddr 0xA0, 0xB0) in one cycle -> emitted on consecutive cycles in order 0xA0 then 0xB0, indices 0 then 1.
REQ-032 SHALL cover: 2 pushes every cycle until occupancy=7 -> in_ready=0; extra store while low -> dropped, overflow_err=1, occupancy unchanged by it.
REQ-033 SHALL cover: 258 single stores -> storeIndex sequence ...254,255,0,1 with no gaps.
REQ-034 SHALL cover: drain_req with 5 entries queued -> in_ready=0, 5 events emitted, drain_done=1 on the edge after the last pop.
REQ-035 SHALL cover: reset asserted with 4 entries queued -> outputs zero immediately (asynchronous), no events after release, occupancy=0.
